truth_table_sweeper: RTL and testbench

- Sequencer that drives the 4-input combinational breadboard function through all 16 input rows, 0 to 15.
- For each row it applies the inputs and waits a fixed settle time.
- It then captures the 5-bit function result and offers it on a valid/ready row stream.
- It folds every accepted row into a 16-bit signature for pass/fail checking.
- It sits between the truth-table logic under test and the result logger/checker, and replaces the fixed-delay loop of the simulation bench with synthesizable control.

---
 rtl/truth_table_sweeper.sv | 85 ++++++++
 tb/tb_truth_table_sweeper.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: steps a 4-input function through rows 0..15, captures each
// settled result onto a valid/ready stream and folds accepted rows into a signature.
module truth_table_sweeper #(
    parameter int SETTLE = 4,
    parameter int NOUT   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic [3:0]      dut_in,
    input  logic [NOUT-1:0] dut_out,
    output logic            row_valid,
    input  logic            row_ready,
    output logic [3:0]      row_index,
    output logic [NOUT-1:0] row_data,
    output logic            busy,
    output logic            done,
    output logic [15:0]     signature
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_APPLY = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [7:0] RELOAD  = 8'(SETTLE - 1);

    logic [1:0] state;
    logic [7:0] cnt;

    assign dut_in = row_index;
    assign busy   = (state == S_APPLY) || (state == S_SEND);
    assign done   = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            row_index <= '0;
            row_data  <= '0;
            row_valid <= 1'b0;
            signature <= '0;
        end else if (abort) begin
            state     <= S_IDLE;
            row_valid <= 1'b0;
            row_index <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    row_index <= '0;
                    if (start) begin
                        state     <= S_APPLY;
                        signature <= '0;
                        cnt       <= RELOAD;
                    end
                end
                S_APPLY: begin
                    if (cnt == 8'd0) begin
                        row_data  <= dut_out;
                        row_valid <= 1'b1;
                        state     <= S_SEND;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_SEND: begin
                    if (row_ready) begin
                        signature <= {signature[14:0], signature[15]} ^ 16'(row_data);
                        row_valid <= 1'b0;
                        if (row_index == 4'd15) begin
                            state <= S_DONE;
                        end else begin
                            row_index <= row_index + 4'd1;
                            cnt       <= RELOAD;
                            state     <= S_APPLY;
                        end
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    row_index <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed checks of the sweeper with loopback and r0 breadboard functions.
module tb_truth_table_sweeper;
    logic        clk, rst_n, start, abort, row_ready, row_valid, busy, done, mode;
    logic [3:0]  dut_in, row_index;
    logic [4:0]  dut_out, row_data;
    logic [15:0] signature, r0_tab;
    int          checks, errors;

    truth_table_sweeper #(.SETTLE(4), .NOUT(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .dut_in(dut_in), .dut_out(dut_out), .row_valid(row_valid), .row_ready(row_ready),
        .row_index(row_index), .row_data(row_data), .busy(busy), .done(done),
        .signature(signature)
    );

    assign r0_tab  = 16'h6F62;
    assign dut_out = mode ? {4'b0, r0_tab[dut_in]} : {1'b0, dut_in};

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sweep(input string tag, input int stall_row, input int stall_n,
                         input bit poke, input logic [15:0] exp_sig, input int exp_done);
        int rows = 0, done_cnt = 0, done_cyc = 0, stalled = 0, busy_bad = 0;
        logic [15:0] msig = 16'h0;
        logic [4:0]  exp_d;
        bit stall;
        row_ready = 1;
        start = 1;
        @(negedge clk);
        start = 0;
        for (int cyc = 1; cyc <= exp_done + 5; cyc++) begin
            @(negedge clk);
            start = 0;
            if (busy !== (cyc < exp_done)) busy_bad++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                start = 1;
            end
            if (poke && cyc == 30) start = 1;
            stall = row_valid && (row_index == 4'(stall_row)) && (stalled < stall_n);
            row_ready = !stall;
            exp_d = mode ? {4'b0, r0_tab[rows]} : 5'(rows);
            if (stall) begin
                stalled++;
                chk({tag, " stall valid"}, row_valid, 1);
                chk({tag, " stall index"}, row_index, stall_row);
                chk({tag, " stall data"}, row_data, exp_d);
                chk({tag, " stall dut_in"}, dut_in, stall_row);
                chk({tag, " stall sig"}, signature, msig);
            end else if (row_valid) begin
                chk({tag, " index"}, row_index, rows);
                chk({tag, " data"}, row_data, exp_d);
                chk({tag, " dut_in"}, dut_in, rows);
                chk({tag, " sig before"}, signature, msig);
                msig = {msig[14:0], msig[15]} ^ 16'(exp_d);
                rows++;
            end
        end
        start = 0;
        row_ready = 1;
        chk({tag, " rows"}, rows, 16);
        chk({tag, " done count"}, done_cnt, 1);
        chk({tag, " done cycle"}, done_cyc, exp_done);
        chk({tag, " busy profile"}, busy_bad, 0);
        chk({tag, " signature"}, signature, exp_sig);
        chk({tag, " model sig"}, signature, msig);
        chk({tag, " row_index end"}, row_index, 0);
    endtask

    initial begin
        int waited, bad;
        checks = 0; errors = 0;
        rst_n = 0; start = 0; abort = 0; row_ready = 1; mode = 0;
        repeat (2) @(negedge clk);
        chk("reset valid", row_valid, 0);
        chk("reset index", row_index, 0);
        chk("reset dut_in", dut_in, 0);
        chk("reset data", row_data, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset sig", signature, 0);
        rst_n = 1;
        @(negedge clk);

        sweep("loopback", -1, 0, 0, 16'h08F7, 80);
        mode = 1;
        sweep("r0", -1, 0, 0, 16'h46F6, 80);
        mode = 0;
        sweep("backpressure", 2, 3, 0, 16'h08F7, 83);

        start = 1;
        @(negedge clk);
        start = 0;
        waited = 0;
        while (!(busy && !row_valid && row_index == 4'd7) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("abort reach row7", waited < 200, 1);
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("abort busy", busy, 0);
        chk("abort dut_in", dut_in, 0);
        chk("abort valid", row_valid, 0);
        chk("abort sig", signature, 16'h0004);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) bad++;
        end
        chk("abort no done", bad, 0);
        sweep("after abort", -1, 0, 0, 16'h08F7, 80);

        sweep("start busy", -1, 0, 1, 16'h08F7, 80);

        start = 1;
        @(negedge clk);
        start = 0;
        waited = 0;
        while (!(row_valid && row_index == 4'd9) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("reset reach row9", waited < 200, 1);
        row_ready = 0;
        #2 rst_n = 0;
        #1;
        chk("async valid", row_valid, 0);
        chk("async index", row_index, 0);
        chk("async dut_in", dut_in, 0);
        chk("async data", row_data, 0);
        chk("async busy", busy, 0);
        chk("async done", done, 0);
        chk("async sig", signature, 0);
        @(negedge clk);
        rst_n = 1;
        row_ready = 1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || row_valid || done) bad++;
        end
        chk("idle after reset", bad, 0);
        sweep("after reset", -1, 0, 0, 16'h08F7, 80);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
